// File: rtl/store_bin.sv
// Write-back stage: snapshots the SAT engine's var/lvl state buses and stores them into the
// global var-state and lvl-state BRAMs. Optional feature macro: STORE_BIN_DIRTY_MASK_EN.
module store_bin #(
  parameter int unsigned NUM_VARS_A_BIN        = 8,
  parameter int unsigned NUM_LVLS_A_BIN        = 8,
  parameter int unsigned WIDTH_VAR             = 12,
  parameter int unsigned WIDTH_LVL             = 16,
  parameter int unsigned WIDTH_BIN_ID          = 10,
  parameter int unsigned WIDTH_VAR_STATES      = 19,
  parameter int unsigned WIDTH_LVL_STATES      = 11,
  parameter int unsigned ADDR_WIDTH_VAR        = 9,
  parameter int unsigned ADDR_WIDTH_VAR_STATES = 9,
  parameter int unsigned ADDR_WIDTH_LVL_STATES = 9
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start_update_i,
  input  logic [WIDTH_BIN_ID-1:0]                    request_bin_num_i,
  input  logic [WIDTH_LVL-1:0]                       base_lvl_i,
  input  logic [WIDTH_LVL-1:0]                       cur_lvl_i,
  input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] var_states_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0] lvl_states_i,
`ifdef STORE_BIN_DIRTY_MASK_EN
  input  logic [NUM_VARS_A_BIN-1:0]                  dirty_mask_i,
`endif
  output logic                                       apply_update_o,
  output logic                                       done_update_o,
  output logic [ADDR_WIDTH_VAR-1:0]                  ram_addr_v_o,
  input  logic [WIDTH_VAR-1:0]                       ram_data_v_i,
  output logic                                       ram_we_vs_o,
  output logic [ADDR_WIDTH_VAR_STATES-1:0]           ram_addr_vs_o,
  output logic [WIDTH_VAR_STATES-1:0]                ram_data_vs_o,
  output logic                                       ram_we_ls_o,
  output logic [ADDR_WIDTH_LVL_STATES-1:0]           ram_addr_ls_o,
  output logic [WIDTH_LVL_STATES-1:0]                ram_data_ls_o
);

  localparam int unsigned VCNT_W = (NUM_VARS_A_BIN > 1) ? $clog2(NUM_VARS_A_BIN) : 1;
  localparam int unsigned LCNT_W = (NUM_LVLS_A_BIN > 1) ? $clog2(NUM_LVLS_A_BIN) : 1;
  localparam int unsigned LSUM_W = WIDTH_LVL + 1;
  localparam logic [VCNT_W-1:0] VCNT_LAST = VCNT_W'(NUM_VARS_A_BIN - 1);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(NUM_LVLS_A_BIN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StVars,
    StVdrain,
    StLvls,
    StDone
  } state_e;

  state_e                        r_state, w_state_d;
  logic [VCNT_W-1:0]             r_vcnt, w_vcnt_d;
  logic [LCNT_W-1:0]             r_lcnt, w_lcnt_d;
  logic [ADDR_WIDTH_VAR-1:0]     r_addr_v, w_addr_v_d;
  logic                          r_apply, w_apply_d;
  logic                          r_vwr_vld;
  logic [VCNT_W-1:0]             r_vwr_idx;
  logic [WIDTH_VAR_STATES-1:0]   r_var_snap [NUM_VARS_A_BIN];
  logic [WIDTH_LVL_STATES-1:0]   r_lvl_snap [NUM_LVLS_A_BIN];
  logic [WIDTH_LVL-1:0]          r_base_lvl;
  logic [WIDTH_LVL-1:0]          r_cur_lvl;

  logic                          w_start;
  logic [ADDR_WIDTH_VAR-1:0]     w_var_base;
  logic                          w_mask_bit;
  logic                          w_vs_en;
  logic [LSUM_W-1:0]             w_lvl_sum;
  logic                          w_ls_en;

  assign w_start = (r_state == StIdle) && start_update_i;

  // Address 0 of the vars-bin RAM is reserved, so bin b starts at (b-1)*N+1.
  assign w_var_base = ADDR_WIDTH_VAR'((32'(request_bin_num_i) - 32'd1) * NUM_VARS_A_BIN + 32'd1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_vcnt_d   = r_vcnt;
    w_lcnt_d   = r_lcnt;
    w_addr_v_d = '0;
    w_apply_d  = r_apply;
    unique case (r_state)
      StIdle: begin
        if (start_update_i) begin
          w_state_d  = StVars;
          w_vcnt_d   = '0;
          w_addr_v_d = w_var_base;
          w_apply_d  = 1'b1;
        end
      end
      StVars: begin
        if (r_vcnt == VCNT_LAST) begin
          w_state_d = StVdrain;
        end else begin
          w_vcnt_d   = r_vcnt + VCNT_W'(1);
          w_addr_v_d = r_addr_v + ADDR_WIDTH_VAR'(1);
        end
      end
      StVdrain: begin
        w_state_d = StLvls;
        w_lcnt_d  = '0;
      end
      StLvls: begin
        if (r_lcnt == LCNT_LAST) begin
          w_state_d = StDone;
        end else begin
          w_lcnt_d = r_lcnt + LCNT_W'(1);
        end
      end
      StDone: begin
        w_state_d = StIdle;
        w_apply_d = 1'b0;
      end
      default: begin
        w_state_d = StIdle;
        w_apply_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vcnt     <= '0;
      r_lcnt     <= '0;
      r_addr_v   <= '0;
      r_apply    <= 1'b0;
      r_vwr_vld  <= 1'b0;
      r_vwr_idx  <= '0;
      r_base_lvl <= '0;
      r_cur_lvl  <= '0;
      for (int i = 0; i < NUM_VARS_A_BIN; i++) r_var_snap[i] <= '0;
      for (int j = 0; j < NUM_LVLS_A_BIN; j++) r_lvl_snap[j] <= '0;
    end else begin
      r_vcnt    <= w_vcnt_d;
      r_lcnt    <= w_lcnt_d;
      r_addr_v  <= w_addr_v_d;
      r_apply   <= w_apply_d;
      // RAM read data arrives one cycle after the address, so the write slot trails r_vcnt.
      r_vwr_vld <= (r_state == StVars);
      r_vwr_idx <= r_vcnt;
      if (w_start) begin
        r_base_lvl <= base_lvl_i;
        r_cur_lvl  <= cur_lvl_i;
        for (int i = 0; i < NUM_VARS_A_BIN; i++) begin
          r_var_snap[i] <= var_states_i[i*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
        end
        for (int j = 0; j < NUM_LVLS_A_BIN; j++) begin
          r_lvl_snap[j] <= lvl_states_i[j*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
        end
      end
    end
  end

`ifdef STORE_BIN_DIRTY_MASK_EN
  logic [NUM_VARS_A_BIN-1:0] r_mask;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mask <= '0;
    end else if (w_start) begin
      r_mask <= dirty_mask_i;
    end
  end

  assign w_mask_bit = r_mask[r_vwr_idx];
`else
  assign w_mask_bit = 1'b1;
`endif

  // Var id 0 marks an empty slot.
  assign w_vs_en   = r_vwr_vld && (ram_data_v_i != '0) && w_mask_bit;
  assign w_lvl_sum = LSUM_W'(r_base_lvl) + LSUM_W'(r_lcnt);
  assign w_ls_en   = (r_state == StLvls) && (w_lvl_sum <= LSUM_W'(r_cur_lvl));

  always_comb begin
    ram_we_vs_o   = w_vs_en;
    ram_addr_vs_o = '0;
    ram_data_vs_o = '0;
    if (w_vs_en) begin
      ram_addr_vs_o = ADDR_WIDTH_VAR_STATES'(ram_data_v_i);
      ram_data_vs_o = r_var_snap[r_vwr_idx];
    end
  end

  always_comb begin
    ram_we_ls_o   = w_ls_en;
    ram_addr_ls_o = '0;
    ram_data_ls_o = '0;
    if (w_ls_en) begin
      ram_addr_ls_o = ADDR_WIDTH_LVL_STATES'(w_lvl_sum);
      ram_data_ls_o = r_lvl_snap[r_lcnt];
    end
  end

  assign apply_update_o = r_apply;
  assign done_update_o  = (r_state == StDone);
  assign ram_addr_v_o   = r_addr_v;

endmodule

// File: tb/tb_store_bin.sv
// Directed bench for store_bin: a transaction-level model predicts every output per cycle,
// plus literal checks on the captured BRAM writes. Honours STORE_BIN_DIRTY_MASK_EN.
module tb_store_bin;

  localparam int NV  = 8;
  localparam int NL  = 8;
  localparam int WV  = 12;
  localparam int WL  = 16;
  localparam int WB  = 10;
  localparam int WVS = 19;
  localparam int WLS = 11;
  localparam int AV  = 9;
  localparam int AVS = 9;
  localparam int ALS = 9;
  localparam int DONE_K = NV + NL + 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start_update_i = 1'b0;
  logic [WB-1:0]      request_bin_num_i = '0;
  logic [WL-1:0]      base_lvl_i = '0;
  logic [WL-1:0]      cur_lvl_i = '0;
  logic [WVS*NV-1:0]  var_states_i = '0;
  logic [WLS*NL-1:0]  lvl_states_i = '0;
`ifdef STORE_BIN_DIRTY_MASK_EN
  logic [NV-1:0]      dirty_mask_i = '1;
`endif
  logic               apply_update_o;
  logic               done_update_o;
  logic [AV-1:0]      ram_addr_v_o;
  logic [WV-1:0]      ram_data_v_i = '0;
  logic               ram_we_vs_o;
  logic [AVS-1:0]     ram_addr_vs_o;
  logic [WVS-1:0]     ram_data_vs_o;
  logic               ram_we_ls_o;
  logic [ALS-1:0]     ram_addr_ls_o;
  logic [WLS-1:0]     ram_data_ls_o;

  always #5 clk = ~clk;

  store_bin dut (
    .clk               (clk),
    .rst               (rst),
    .start_update_i    (start_update_i),
    .request_bin_num_i (request_bin_num_i),
    .base_lvl_i        (base_lvl_i),
    .cur_lvl_i         (cur_lvl_i),
    .var_states_i      (var_states_i),
    .lvl_states_i      (lvl_states_i),
`ifdef STORE_BIN_DIRTY_MASK_EN
    .dirty_mask_i      (dirty_mask_i),
`endif
    .apply_update_o    (apply_update_o),
    .done_update_o     (done_update_o),
    .ram_addr_v_o      (ram_addr_v_o),
    .ram_data_v_i      (ram_data_v_i),
    .ram_we_vs_o       (ram_we_vs_o),
    .ram_addr_vs_o     (ram_addr_vs_o),
    .ram_data_vs_o     (ram_data_vs_o),
    .ram_we_ls_o       (ram_we_ls_o),
    .ram_addr_ls_o     (ram_addr_ls_o),
    .ram_data_ls_o     (ram_data_ls_o)
  );

  // Vars-bin RAM, one-cycle read latency.
  logic [WV-1:0] vmem [1<<AV];
  always @(posedge clk) ram_data_v_i <= vmem[ram_addr_v_o];

  // Transaction model: m_k is the cycle offset from the accepted start pulse.
  int            cyc = 0;
  bit            m_act = 1'b0;
  int            m_k = 0;
  logic [WVS-1:0] m_vs [NV];
  logic [WLS-1:0] m_ls [NL];
  logic [AV-1:0]  m_base;
  logic [WL-1:0]  m_blvl, m_clvl;
  logic [NV-1:0]  m_mask;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_act = 1'b0;
      m_k   = 0;
    end else if (m_act) begin
      if (m_k == DONE_K) begin
        m_act = 1'b0;
        m_k   = 0;
      end else begin
        m_k++;
      end
    end else if (start_update_i) begin
      m_act = 1'b1;
      m_k   = 1;
      for (int i = 0; i < NV; i++) m_vs[i] = var_states_i[i*WVS +: WVS];
      for (int j = 0; j < NL; j++) m_ls[j] = lvl_states_i[j*WLS +: WLS];
      m_base = AV'((int'(request_bin_num_i) - 1) * NV + 1);
      m_blvl = base_lvl_i;
      m_clvl = cur_lvl_i;
`ifdef STORE_BIN_DIRTY_MASK_EN
      m_mask = dirty_mask_i;
`else
      m_mask = '1;
`endif
    end
  end

  int   n_vec = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  int   n_vsw, n_lsw, n_done, n_apply, done_cyc;
  logic [WVS-1:0] vs_sh [1<<AVS];
  logic [WLS-1:0] ls_sh [1<<ALS];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic           e_apply, e_done, e_we_vs, e_we_ls;
    logic [AV-1:0]  e_addr_v;
    logic [AVS-1:0] e_addr_vs;
    logic [WVS-1:0] e_data_vs;
    logic [ALS-1:0] e_addr_ls;
    logic [WLS-1:0] e_data_ls;
    logic [WV-1:0]  id;
    logic [WL:0]    g;
    int             s, j;
    if (chk_en) begin
      e_apply = 0; e_done = 0; e_we_vs = 0; e_we_ls = 0;
      e_addr_v = '0; e_addr_vs = '0; e_data_vs = '0; e_addr_ls = '0; e_data_ls = '0;
      if (m_act) begin
        e_apply = 1'b1;
        e_done  = (m_k == DONE_K);
        if (m_k >= 1 && m_k <= NV) e_addr_v = m_base + AV'(m_k - 1);
        if (m_k >= 2 && m_k <= NV + 1) begin
          s  = m_k - 2;
          id = vmem[m_base + AV'(s)];
          if (id != '0 && m_mask[s]) begin
            e_we_vs   = 1'b1;
            e_addr_vs = AVS'(id);
            e_data_vs = m_vs[s];
          end
        end
        if (m_k >= NV + 2 && m_k <= NV + NL + 1) begin
          j = m_k - NV - 2;
          g = (WL+1)'(m_blvl) + (WL+1)'(j);
          if (g <= (WL+1)'(m_clvl)) begin
            e_we_ls   = 1'b1;
            e_addr_ls = ALS'(g);
            e_data_ls = m_ls[j];
          end
        end
      end
      chk("apply", apply_update_o, e_apply);
      chk("done", done_update_o, e_done);
      chk("addr_v", ram_addr_v_o, e_addr_v);
      chk("we_vs", ram_we_vs_o, e_we_vs);
      chk("addr_vs", ram_addr_vs_o, e_addr_vs);
      chk("data_vs", ram_data_vs_o, e_data_vs);
      chk("we_ls", ram_we_ls_o, e_we_ls);
      chk("addr_ls", ram_addr_ls_o, e_addr_ls);
      chk("data_ls", ram_data_ls_o, e_data_ls);
      chk("port_excl", ram_we_vs_o & ram_we_ls_o, 0);
      if (ram_we_vs_o === 1'b1) begin n_vsw++; vs_sh[ram_addr_vs_o] = ram_data_vs_o; end
      if (ram_we_ls_o === 1'b1) begin n_lsw++; ls_sh[ram_addr_ls_o] = ram_data_ls_o; end
      if (done_update_o === 1'b1) begin n_done++; done_cyc = cyc; end
      if (apply_update_o === 1'b1) n_apply++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    n_vsw = 0; n_lsw = 0; n_done = 0; n_apply = 0; done_cyc = -1;
    for (int a = 0; a < (1 << AVS); a++) vs_sh[a] = '0;
    for (int a = 0; a < (1 << ALS); a++) ls_sh[a] = '0;
  endtask

  task automatic set_states();
    for (int i = 0; i < NV; i++) var_states_i[i*WVS +: WVS] = WVS'(32'h1A000 + i * 32'h101);
    for (int j = 0; j < NL; j++) lvl_states_i[j*WLS +: WLS] = WLS'(32'h400 + j * 3);
  endtask

  // Drives the start pulse in the current cycle (cycle 0); returns in cycle 1.
  task automatic start_tx(input int bin, input int bl, input int cl, output int c0);
    request_bin_num_i = WB'(bin);
    base_lvl_i        = WL'(bl);
    cur_lvl_i         = WL'(cl);
    set_states();
    start_update_i    = 1'b1;
    c0 = cyc;
    tick();
    start_update_i    = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (n_done == 0 && n < 40) begin
      tick();
      n++;
    end
    if (n_done == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: done pulse got none within 40 cycles, want one", nm);
    end
    tick();
    tick();
  endtask

  initial begin
    int c0;
    for (int a = 0; a < (1 << AV); a++) vmem[a] = '0;
    for (int i = 0; i < NV; i++) vmem[9 + i] = WV'(5 + i);

    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_apply", apply_update_o, 0);
    chk("rst_done", done_update_o, 0);
    chk("rst_addr_v", ram_addr_v_o, 0);
    rst = 1'b1;
    tick();
    tick();

    // Full bin 2: ids 5..12, all levels valid.
    clr();
    start_tx(2, 3, 20, c0);
    wait_done("t1");
    chk("t1_done_k", done_cyc - c0, 18);
    chk("t1_apply_n", n_apply, 18);
    chk("t1_vs_n", n_vsw, 8);
    chk("t1_ls_n", n_lsw, 8);
    chk("t1_vs5", vs_sh[5], 32'h1A000);
    chk("t1_vs12", vs_sh[12], 32'h1A707);
    chk("t1_ls3", ls_sh[3], 32'h400);
    chk("t1_ls10", ls_sh[10], 32'h415);

    // Snapshot isolation and ignored restart in cycle 4.
    clr();
    start_tx(2, 3, 20, c0);
    var_states_i = ~var_states_i;
    tick(); tick(); tick();
    start_update_i = 1'b1;
    tick();
    start_update_i = 1'b0;
    wait_done("t4");
    chk("t4_done_k", done_cyc - c0, 18);
    chk("t4_done_n", n_done, 1);
    chk("t4_vs5", vs_sh[5], 32'h1A000);
    chk("t4_vs12", vs_sh[12], 32'h1A707);

    // Empty slots 3 and 7.
    vmem[12] = '0;
    vmem[16] = '0;
    clr();
    start_tx(2, 3, 20, c0);
    wait_done("t2");
    chk("t2_vs_n", n_vsw, 6);
    chk("t2_vs8", vs_sh[8], 32'h0);
    chk("t2_vs9", vs_sh[9], 32'h1A404);
    vmem[12] = WV'(8);
    vmem[16] = WV'(12);

    // Only levels 10..12 valid.
    clr();
    start_tx(2, 10, 12, c0);
    wait_done("t3");
    chk("t3_ls_n", n_lsw, 3);
    chk("t3_ls12", ls_sh[12], 32'h406);
    chk("t3_ls13", ls_sh[13], 32'h0);

    // Level sum crosses 2^16: no wrap-around writes.
    clr();
    start_tx(2, 16'hFFFE, 16'hFFFF, c0);
    wait_done("tw");
    chk("tw_ls_n", n_lsw, 2);
    chk("tw_ls1fe", ls_sh[9'h1FE], 32'h400);
    chk("tw_ls1ff", ls_sh[9'h1FF], 32'h403);

    // Reset asserted in cycle 6 aborts the transfer.
    clr();
    start_tx(2, 3, 20, c0);
    tick(); tick(); tick(); tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    clr();
    repeat (25) tick();
    chk("t5_vs_n", n_vsw, 0);
    chk("t5_ls_n", n_lsw, 0);
    chk("t5_done_n", n_done, 0);
    chk("t5_apply_n", n_apply, 0);
    clr();
    start_tx(2, 3, 20, c0);
    wait_done("t5b");
    chk("t5b_done_k", done_cyc - c0, 18);
    chk("t5b_vs_n", n_vsw, 8);

`ifdef STORE_BIN_DIRTY_MASK_EN
    clr();
    dirty_mask_i = 8'b0000_0101;
    start_tx(2, 3, 20, c0);
    wait_done("tm");
    chk("tm_vs_n", n_vsw, 2);
    chk("tm_vs5", vs_sh[5], 32'h1A000);
    chk("tm_vs7", vs_sh[7], 32'h1A202);
    chk("tm_ls_n", n_lsw, 8);
    dirty_mask_i = '1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
